pipemem_stage: RTL

Memory stage of the five-stage pipelined CPU. Consumes the EXE stage results (ALU result, destination register number, store data and control bits), holds them in the EX/MEM pipeline register, and performs the data-memory access over a req/ack handshake. Stalls the upstream pipeline while an access is outstanding, then forwards the retired result into the MEM/WB pipeline register.

---
 rtl/pipemem_stage_if.sv | 28 ++
 rtl/pipemem_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipemem_stage_if.sv
// Data-memory req/ack bus between the pipeline MEM stage (master) and the
// data memory (slave). The request side is held stable while dm_req is high.
interface pipemem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata
  );
endinterface

// File: rtl/pipemem_stage.sv
// MEM stage of the five-stage pipeline: EX/MEM register, data-memory access
// over a req/ack handshake with timeout abort, and the MEM/WB register.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, loads/stores with
// ealu[1:0] != 00 never reach memory and retire as a bubble with exception
// code 10. When undefined, low address bits are passed through untouched.
module pipemem_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   ewreg,
  input  logic                   em2reg,
  input  logic                   ewmem,
  input  logic [31:0]            ealu,
  input  logic [31:0]            eb,
  input  logic [4:0]             ern,
  pipemem_stage_if.master        dm,
  output logic                   mstall,
  output logic                   mwreg,
  output logic                   mm2reg,
  output logic [31:0]            malu,
  output logic [31:0]            mmo,
  output logic [4:0]             mrn,
  output logic                   mexc,
  output logic [1:0]             mexc_code
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // A zero timeout disables the abort path entirely.
  localparam logic       TO_EN   = (TIMEOUT_CYC != 0) ? 1'b1 : 1'b0;
  localparam logic [7:0] TO_LAST = (TIMEOUT_CYC != 0) ? 8'(TIMEOUT_CYC - 1) : 8'd0;

  state_t      state_r, state_next_s;
  logic [7:0]  cnt_r;
  logic        wreg_q, m2reg_q, wmem_q, misal_q;
  logic [31:0] malu_q, b_q;
  logic [4:0]  rn_q;

  logic        busy_s, timeout_hit_s, load_en_s, misal_s, mem_op_s;

  assign mem_op_s = em2reg | ewmem;

`ifdef MISALIGN_TRAP_EN
  assign misal_s = mem_op_s & (ealu[1:0] != 2'b00);
`else
  assign misal_s = 1'b0;
`endif

  // FSM outputs: request, stall and the edge-enable for the EX/MEM register.
  always_comb begin
    busy_s        = (state_r == BUSY);
    timeout_hit_s = busy_s & TO_EN & (cnt_r == TO_LAST) & ~dm.dm_ack;
    mstall        = busy_s & ~dm.dm_ack & ~timeout_hit_s;
    load_en_s     = ~mstall;
  end

  assign dm.dm_req   = busy_s;
  assign dm.dm_we    = wmem_q;
  assign dm.dm_addr  = malu_q;
  assign dm.dm_wdata = b_q;

  // Next state: a new instruction is examined on every non-stalled edge.
  always_comb begin
    state_next_s = state_r;
    if (load_en_s) begin
      if (mem_op_s && !misal_s) begin
        state_next_s = BUSY;
      end else begin
        state_next_s = IDLE;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State register; reset drops dm_req immediately and discards any access.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait counter: cleared whenever a new instruction is captured, counts stall cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= 8'd0;
    end else if (load_en_s) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // EX/MEM pipeline register, frozen while the stage stalls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
      misal_q <= 1'b0;
      malu_q  <= 32'd0;
      b_q     <= 32'd0;
      rn_q    <= 5'd0;
    end else if (load_en_s) begin
      wreg_q  <= ewreg;
      m2reg_q <= em2reg;
      wmem_q  <= ewmem;
      misal_q <= misal_s;
      malu_q  <= ealu;
      b_q     <= eb;
      rn_q    <= ern;
    end else begin
      wreg_q  <= wreg_q;
      m2reg_q <= m2reg_q;
      wmem_q  <= wmem_q;
      misal_q <= misal_q;
      malu_q  <= malu_q;
      b_q     <= b_q;
      rn_q    <= rn_q;
    end
  end

  // MEM/WB pipeline register: retire, bubble on stall/abort, exception pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mwreg     <= 1'b0;
      mm2reg    <= 1'b0;
      malu      <= 32'd0;
      mmo       <= 32'd0;
      mrn       <= 5'd0;
      mexc      <= 1'b0;
      mexc_code <= 2'b00;
    end else if (busy_s) begin
      if (dm.dm_ack) begin
        // Stores also latch dm_rdata; write-back ignores it for them.
        mwreg     <= wreg_q;
        mm2reg    <= m2reg_q;
        malu      <= malu_q;
        mmo       <= dm.dm_rdata;
        mrn       <= rn_q;
        mexc      <= 1'b0;
        mexc_code <= 2'b00;
      end else begin
        // Still waiting, or aborted by timeout: either way a bubble.
        mwreg     <= 1'b0;
        mm2reg    <= 1'b0;
        mexc      <= timeout_hit_s;
        mexc_code <= timeout_hit_s ? 2'b01 : 2'b00;
      end
    end else if (misal_q) begin
      mwreg     <= 1'b0;
      mm2reg    <= 1'b0;
      mexc      <= 1'b1;
      mexc_code <= 2'b10;
    end else begin
      // Non-memory instruction (or bubble); mmo keeps the last load data.
      mwreg     <= wreg_q;
      mm2reg    <= m2reg_q;
      malu      <= malu_q;
      mrn       <= rn_q;
      mexc      <= 1'b0;
      mexc_code <= 2'b00;
    end
  end

endmodule
